// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: field positions, opcode map,
// instruction classes and the combinational decode of one instruction word.
package isa_pkg;

  localparam int OFF_MSB = 31;
  localparam int OFF_LSB = 19;
  localparam int RA_MSB  = 18;
  localparam int RA_LSB  = 14;
  localparam int RB_MSB  = 13;
  localparam int RB_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 4;
  localparam int OP_MSB  = 3;
  localparam int OP_LSB  = 0;
  localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_ADDI = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BGT  = 4'd11,
    OP_BGE  = 4'd12
  } opcode_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_ALUI    = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_t;

  typedef struct packed {
    instr_class_t     cls;
    logic [3:0]       op;
    logic [4:0]       ra;
    logic [4:0]       rb;
    logic [4:0]       dst;
    logic             we;
    logic             mem_re;
    logic             mem_we;
    logic [OFF_W-1:0] off;
  } decode_t;

  typedef struct packed {
    decode_t bundle;
    logic    use_ra;
    logic    use_rb;
  } decode_info_t;

  // dst defaults to the rd field; only loads write through rb.
  function automatic decode_info_t decode_fn(input logic [31:0] instr);
    decode_info_t info;
    info.bundle.cls    = CLS_ILLEGAL;
    info.bundle.op     = instr[OP_MSB:OP_LSB];
    info.bundle.ra     = instr[RA_MSB:RA_LSB];
    info.bundle.rb     = instr[RB_MSB:RB_LSB];
    info.bundle.dst    = instr[RD_MSB:RD_LSB];
    info.bundle.we     = 1'b0;
    info.bundle.mem_re = 1'b0;
    info.bundle.mem_we = 1'b0;
    info.bundle.off    = instr[OFF_MSB:OFF_LSB];
    info.use_ra        = 1'b0;
    info.use_rb        = 1'b0;
    case (instr[OP_MSB:OP_LSB])
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR: begin
        info.bundle.cls = CLS_ALU;
        info.bundle.we  = 1'b1;
        info.use_ra     = 1'b1;
        info.use_rb     = 1'b1;
      end
      OP_ADDI: begin
        info.bundle.cls = CLS_ALUI;
        info.bundle.we  = 1'b1;
        info.use_ra     = 1'b1;
      end
      OP_LW: begin
        info.bundle.cls    = CLS_LOAD;
        info.bundle.dst    = instr[RB_MSB:RB_LSB];
        info.bundle.we     = 1'b1;
        info.bundle.mem_re = 1'b1;
        info.use_ra        = 1'b1;
      end
      OP_SW: begin
        info.bundle.cls    = CLS_STORE;
        info.bundle.mem_we = 1'b1;
        info.use_ra        = 1'b1;
        info.use_rb        = 1'b1;
      end
      OP_BEQ, OP_BGT, OP_BGE: begin
        info.bundle.cls = CLS_BRANCH;
        info.use_ra     = 1'b1;
        info.use_rb     = 1'b1;
      end
      default: ;
    endcase
    if (info.bundle.dst == 5'd0) info.bundle.we = 1'b0;
    return info;
  endfunction

endpackage

// File: rtl/instr_decode_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set on issue,
// cleared on writeback, with a combinational hazard query.
module scoreboard
  import isa_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_en_i,
  input  logic [4:0]       set_dst_i,
  input  logic             clr_en_i,
  input  logic [4:0]       clr_rd_i,
  input  logic [4:0]       q_ra_i,
  input  logic             q_use_ra_i,
  input  logic [4:0]       q_rb_i,
  input  logic             q_use_rb_i,
  input  logic [4:0]       q_dst_i,
  input  logic             q_we_i,
  output logic             hazard_o,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;

  // NOTE: every variable gets a default before any conditional write, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_en_i && set_dst_i != 5'd0) w_set_mask[set_dst_i] = 1'b1;
    if (clr_en_i && clr_rd_i != 5'd0)  w_clr_mask[clr_rd_i] = 1'b1;
  end

  // Set is OR'ed in after the clear, so a same-edge set of the same register wins.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
  end

  assign hazard_o = (q_use_ra_i && r_busy[q_ra_i]) ||
                    (q_use_rb_i && r_busy[q_rb_i]) ||
                    (q_we_i     && r_busy[q_dst_i]);
  assign busy_o   = r_busy;

endmodule

// File: rtl/instr_decode.sv
// Decode stage: valid/ready input handshake, one output register slot, and a
// scoreboard that stalls instructions touching registers with writes in flight.
module instr_decode
  import isa_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NREGS     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          in_instr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2:0]           out_class_o,
  output logic [3:0]           out_op_o,
  output logic [4:0]           out_ra_o,
  output logic [4:0]           out_rb_o,
  output logic [4:0]           out_dst_o,
  output logic                 out_we_o,
  output logic                 out_mem_re_o,
  output logic                 out_mem_we_o,
  output logic [DATAWIDTH-1:0] out_imm_o,
  input  logic                 wb_valid_i,
  input  logic [4:0]           wb_rd_i,
  output logic [NREGS-1:0]     busy_o
);

  decode_info_t w_info;
  logic         w_hazard;
  logic         w_accept;
  logic         r_valid;
  decode_t      r_bundle;

  assign w_info     = decode_fn(in_instr_i);
  assign in_ready_o = (!r_valid || out_ready_i) && !w_hazard;
  assign w_accept   = in_valid_i && in_ready_o;

  scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (w_accept && w_info.bundle.we),
    .set_dst_i  (w_info.bundle.dst),
    .clr_en_i   (wb_valid_i),
    .clr_rd_i   (wb_rd_i),
    .q_ra_i     (w_info.bundle.ra),
    .q_use_ra_i (w_info.use_ra),
    .q_rb_i     (w_info.bundle.rb),
    .q_use_rb_i (w_info.use_rb),
    .q_dst_i    (w_info.bundle.dst),
    .q_we_i     (w_info.bundle.we),
    .hazard_o   (w_hazard),
    .busy_o     (busy_o)
  );

  // NOTE: the data slot is reset as well as the valid bit, so outputs read
  // as zero after reset rather than leftover state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_bundle <= w_info.bundle;
    end else if (out_ready_i) begin
      r_valid  <= 1'b0;
    end
  end

  assign out_valid_o  = r_valid;
  assign out_class_o  = r_bundle.cls;
  assign out_op_o     = r_bundle.op;
  assign out_ra_o     = r_bundle.ra;
  assign out_rb_o     = r_bundle.rb;
  assign out_dst_o    = r_bundle.dst;
  assign out_we_o     = r_bundle.we;
  assign out_mem_re_o = r_bundle.mem_re;
  assign out_mem_we_o = r_bundle.mem_we;
  assign out_imm_o    = {{(DATAWIDTH-OFF_W){r_bundle.off[OFF_W-1]}}, r_bundle.off};

endmodule

// File: doc/instr_decode.md
# instr_decode

Decode stage between instruction fetch and execute. It accepts 32-bit instruction words over a valid/ready handshake and splits them into fields. It classifies the opcode, sign-extends the offset, and tracks in-flight destination registers in a scoreboard. An instruction is held back while any register it uses still has a write outstanding.

## Interface
- `DATAWIDTH`, 32: width of the sign-extended immediate.
- `NREGS`, 32: architectural registers, indexed by 5-bit fields.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `in_valid_i` in 1: fetch presents `in_instr_i`.
- `in_ready_o` out 1: decode accepts this cycle.
- `in_instr_i` in 32: instruction word with fields offset[31:19], ra[18:14], rb[13:9], rd[8:4], opcode[3:0].
- `out_valid_o` out 1: decoded bundle valid.
- `out_ready_i` in 1: execute takes the bundle.
- `out_class_o` out 3: instruction class, one of ALU, ALUI, LOAD, STORE, BRANCH, ILLEGAL.
- `out_op_o` out 4: raw opcode.
- `out_ra_o` out 5: source register A.
- `out_rb_o` out 5: source register B.
- `out_dst_o` out 5: destination register.
- `out_we_o` out 1: register write.
- `out_mem_re_o` out 1: memory read.
- `out_mem_we_o` out 1: memory write.
- `out_imm_o` out DATAWIDTH: offset[31:19] sign-extended.
- `wb_valid_i` in 1: writeback retires register `wb_rd_i`.
- `wb_rd_i` in 5: register being retired.
- `busy_o` out NREGS: scoreboard state, for debug.

## Operation
- Opcode groups, using the shared opcode definitions:
  - ADD/SUB/MUL/DIV/AND/OR/XOR: class ALU. Uses ra and rb. dst=rd, we=1.
  - ADDI: class ALUI. Uses ra. dst=rd, we=1.
  - LW: class LOAD. Uses ra (base). dst=rb, we=1, mem_re=1.
  - SW: class STORE. Uses ra (base) and rb (data). we=0, mem_we=1.
  - BEQ/BGT/BGE: class BRANCH. Uses ra and rb. we=0.
  - Any other opcode: class ILLEGAL. All enables 0. Passed through so execute can trap.
- Register 0:
  - Reads as zero; never busy.
  - A write with dst=0 forces we=0.
- Hazard: a used source register, or dst when we=1, has its `busy` bit set. `in_ready_o = (!out_valid_o || out_ready_i) && !hazard(in_instr_i)`; `in_ready_o` is combinational from `in_instr_i` and registered state only.
- Accept, i.e. `in_valid_i && in_ready_o`:
  - The bundle is registered into the output slot.
  - If we=1, `busy[dst]` is set at the same edge.
  - At most one outstanding writer exists per register.
- Writeback:
  - `wb_valid_i` clears `busy[wb_rd_i]` at the next edge.
  - Writeback to r0 or to a non-busy register is ignored.
- Same-edge set and clear of the same register: set wins.
- No bypass: the hazard check sees only the registered busy state. A writeback in cycle N unblocks an accept in cycle N+1 at the earliest.
- Output slot:
  - Holds its value while `out_valid_o && !out_ready_i`.
  - Is replaced when `out_ready_i` is high and a new accept occurs in the same cycle; this gives full throughput for a hazard-free stream.

## Timing
- Latency: accepted at edge N, valid from cycle N+1 (one register stage).
- Throughput: 1 instruction/cycle when there is no hazard and no backpressure.
- Reset values:
  - `out_valid_o`=0 and all `out_*` data fields=0.
  - `busy`=0.
  - `in_ready_o`=1 once reset deasserts with an idle output.
- Reset mid-stream:
  - The slot is dropped and all busy bits are cleared at the reset edge.
  - Writebacks presented during reset are ignored.
- Outputs are stable while `out_valid_o && !out_ready_i`; execute may sample them at any point.

## Structure
- `isa_pkg` holds:
  - The field bit positions.
  - The `instr_class_t` enum.
  - A `decode_t` struct holding the bundle.
  - A `decode_fn` pure function (instruction → `decode_t`, plus the per-instruction source-use flags).
- Sub-module `scoreboard`:
  - Holds the busy vector, with set (dst, en) and clear (rd, en) ports.
  - Provides a hazard query for two sources plus one destination.
  - Set-over-clear priority lives here.
- The top level contains the handshake and the output register only.

## Test plan
- ADD ra=1, rb=1, rd=3 accepted at edge N → in cycle N+1: class=ALU, ra=1, rb=1, dst=3, we=1; `busy_o[3]`=1.
- ADD ra=1, rb=3, rd=22 right after the above → `in_ready_o`=0 until `wb_valid_i` with `wb_rd_i`=3; accepted exactly one cycle after the writeback edge.
- ADDI off=69, ra=0, rd=1 → imm=32'd69, class=ALUI. Off=13'h1FFF → imm=32'hFFFF_FFFF.
- LW off=15, ra=0, rb=4 → dst=4, mem_re=1, we=1, `busy_o[4]`=1. SW off=16, ra=0, rb=7 → mem_we=1, we=0, busy unchanged. BEQ ra=rb=4 stalls while r4 is busy.
- Unused opcode → class=ILLEGAL, all enables 0, no busy bit. ADD with rd=0 → we=0, no stall on a following reader of r0.
- `out_ready_i`=0 for 3 cycles with a stream pending → bundle held stable, `in_ready_o`=0. Assert `rst_i` with busy bits set → next cycle `out_valid_o`=0 and `busy_o`=0.
